// File: rtl/glitch_pkg.sv
// Shared types and default constants for the glitch-path self-test monitor.
package glitch_pkg;

    localparam int unsigned MON_CNT_W = 32;

    localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd12_000_000;
    localparam logic [31:0] DEF_EXP_DELAY      = 32'd12_000_000;
    localparam logic [31:0] DEF_EXP_WIDTH      = 32'd12;
    localparam logic [31:0] DEF_TOLERANCE      = 32'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        WIDTH  = 2'd2,
        REPORT = 2'd3
    } mon_state_t;

    typedef struct packed {
        logic [MON_CNT_W-1:0] delay;
        logic [MON_CNT_W-1:0] width;
        logic                 timeout;
        logic                 pass;
    } mon_result_t;

endpackage

// File: rtl/glitch_monitor_if.sv
// Result bundle published by the glitch monitor.
interface glitch_monitor_if
    import glitch_pkg::*;
#(
    parameter int unsigned CNT_W = MON_CNT_W
) ();

    logic [CNT_W-1:0] delay_cycles;
    logic [CNT_W-1:0] width_cycles;
    logic             result_valid;
    logic             timeout;
    logic             pass;
    logic             busy;

    modport master (
        output delay_cycles, width_cycles, result_valid, timeout, pass, busy
    );

    modport slave (
        input delay_cycles, width_cycles, result_valid, timeout, pass, busy
    );

endinterface

// File: rtl/glitch_monitor_sync_edge.sv
// 2-FF synchronizer with registered rise/fall strobes; optionally holds off
// rise strobes until the synchronized line has been seen low after reset.
module sync_edge #(
    parameter bit GATE_RISE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_o,
    output logic fall_o
);

    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       hist_q, hist_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       armed_q, armed_d;
    logic [1:0] fill_q, fill_d;

    // fill_q[1] marks that sync_q holds a real sample rather than its reset value
    always_comb begin
        meta_d  = din;
        sync_d  = meta_q;
        hist_d  = sync_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~sync_q);
        rise_d  = sync_q & ~hist_q & (armed_q | ~GATE_RISE);
        fall_d  = ~sync_q & hist_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            armed_q <= armed_d;
            fill_q  <= fill_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/glitch_monitor.sv
// Measures trigger-to-glitch delay and glitch width in cycles and publishes
// each result with a pass/fail verdict against the expected values.
module glitch_monitor
    import glitch_pkg::*;
#(
    parameter int unsigned      CNT_W          = MON_CNT_W,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = CNT_W'(DEF_TIMEOUT_CYCLES),
    parameter logic [CNT_W-1:0] EXP_DELAY      = CNT_W'(DEF_EXP_DELAY),
    parameter logic [CNT_W-1:0] EXP_WIDTH      = CNT_W'(DEF_EXP_WIDTH),
    parameter logic [CNT_W-1:0] TOLERANCE      = CNT_W'(DEF_TOLERANCE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic             glitch,
    glitch_monitor_if.master res_if
);

    logic trig_rise, unused_trig_fall;
    logic glitch_rise, glitch_fall;

    sync_edge #(.GATE_RISE(1'b1)) u_trig_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (trigger),
        .rise_o (trig_rise),
        .fall_o (unused_trig_fall)
    );

    sync_edge #(.GATE_RISE(1'b0)) u_glitch_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (glitch),
        .rise_o (glitch_rise),
        .fall_o (glitch_fall)
    );

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] delay_cap_q, delay_cap_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             timeout_q, timeout_d;
    logic             pass_q, pass_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic             fin;
    logic             fin_to;
    logic [CNT_W-1:0] fin_delay, fin_width;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // |a - b| <= TOLERANCE, difference taken one bit wider so it cannot wrap
    function automatic logic within_tol(input logic [CNT_W-1:0] a,
                                        input logic [CNT_W-1:0] b);
        logic [CNT_W:0] diff;
        diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
        return diff <= {1'b0, TOLERANCE};
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        delay_cap_d = delay_cap_q;
        delay_d     = delay_q;
        width_d     = width_q;
        timeout_d   = timeout_q;
        pass_d      = pass_q;
        valid_d     = 1'b0;
        fin         = 1'b0;
        fin_to      = 1'b0;
        fin_delay   = '0;
        fin_width   = '0;

        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    cnt_d = '0;
                    if (glitch_rise) begin
                        delay_cap_d = '0;
                        state_d     = WIDTH;
                    end else begin
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                cnt_d = cnt_inc;
                if (glitch_rise) begin
                    delay_cap_d = cnt_inc;
                    cnt_d       = '0;
                    state_d     = WIDTH;
                end else if (cnt_inc == TIMEOUT_CYCLES) begin
                    fin       = 1'b1;
                    fin_to    = 1'b1;
                    fin_delay = cnt_inc;
                end
            end
            WIDTH: begin
                cnt_d     = cnt_inc;
                fin_delay = delay_cap_q;
                fin_width = cnt_inc;
                if (glitch_fall) begin
                    fin = 1'b1;
                end else if (cnt_inc == TIMEOUT_CYCLES) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Results are loaded on entry to REPORT so result_valid coincides with it
        if (fin) begin
            state_d   = REPORT;
            delay_d   = fin_delay;
            width_d   = fin_width;
            timeout_d = fin_to;
            pass_d    = ~fin_to & within_tol(fin_delay, EXP_DELAY)
                                & within_tol(fin_width, EXP_WIDTH);
            valid_d   = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            delay_cap_q <= '0;
            delay_q     <= '0;
            width_q     <= '0;
            timeout_q   <= 1'b0;
            pass_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            delay_cap_q <= delay_cap_d;
            delay_q     <= delay_d;
            width_q     <= width_d;
            timeout_q   <= timeout_d;
            pass_q      <= pass_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign res_if.delay_cycles = delay_q;
    assign res_if.width_cycles = width_q;
    assign res_if.result_valid = valid_q;
    assign res_if.timeout      = timeout_q;
    assign res_if.pass         = pass_q;
    assign res_if.busy         = busy_q;

endmodule
